// File: rtl/sh_reg_ctrl.sv
// Command-driven sequencer that streams a parallel word bit-serially into an
// external shift register via shl/shr/d, then samples the register's Q as a response.
module sh_reg_ctrl #(
    parameter int WIDTH = 8,
    parameter int LENW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [LENW-1:0]  cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic             shl,
    output logic             shr,
    output logic             d,
    input  logic [WIDTH-1:0] sr_q,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_q,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [LENW-1:0] WIDTH_L = LENW'(WIDTH);

    state_t           state, state_nx;
    logic [LENW-1:0]  cnt, cnt_nx;
    logic             dir, dir_nx;
    logic [WIDTH-1:0] sdata, sdata_nx;
    logic             shl_nx, shr_nx, d_nx, rsp_valid_nx;
    logic [WIDTH-1:0] rsp_q_nx;
    logic             ready_nx;
    logic [LENW-1:0]  len_clamped;
    logic [WIDTH-1:0] aligned;

    // Out-of-range lengths collapse to a full-width load. For left shifts the
    // slice is pre-aligned so its top bit sits at the MSB and streams out first.
    assign len_clamped = ((cmd_len == '0) || (cmd_len > WIDTH_L)) ? WIDTH_L : cmd_len;
    assign aligned     = cmd_data << (WIDTH_L - len_clamped);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nx     = state;
        cnt_nx       = cnt;
        dir_nx       = dir;
        sdata_nx     = sdata;
        shl_nx       = 1'b0;
        shr_nx       = 1'b0;
        d_nx         = 1'b0;
        rsp_valid_nx = 1'b0;
        rsp_q_nx     = rsp_q;

        case (state)
            IDLE: begin
                if (cmd_valid && !abort) begin
                    state_nx = SHIFT;
                    cnt_nx   = len_clamped;
                    dir_nx   = cmd_dir;
                    shl_nx   = !cmd_dir;
                    shr_nx   = cmd_dir;
                    if (cmd_dir) begin
                        d_nx     = cmd_data[0];
                        sdata_nx = cmd_data >> 1;
                    end else begin
                        d_nx     = aligned[WIDTH-1];
                        sdata_nx = aligned << 1;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (cnt == LENW'(1)) begin
                    state_nx = CAPTURE;
                end else begin
                    cnt_nx   = cnt - LENW'(1);
                    shl_nx   = !dir;
                    shr_nx   = dir;
                    d_nx     = dir ? sdata[0] : sdata[WIDTH-1];
                    sdata_nx = dir ? (sdata >> 1) : (sdata << 1);
                end
            end
            CAPTURE: begin
                state_nx = IDLE;
                if (!abort) begin
                    rsp_valid_nx = 1'b1;
                    rsp_q_nx     = sr_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ready_nx = (state_nx == IDLE);

    // NOTE: all state and outputs update with non-blocking assignments so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            dir       <= 1'b0;
            sdata     <= '0;
            shl       <= 1'b0;
            shr       <= 1'b0;
            d         <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            dir       <= dir_nx;
            sdata     <= sdata_nx;
            shl       <= shl_nx;
            shr       <= shr_nx;
            d         <= d_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_q     <= rsp_q_nx;
            cmd_ready <= ready_nx;
            busy      <= !ready_nx;
        end
    end

    // Driving both shift controls at once would corrupt the register.
    always_ff @(posedge clk) begin
        assert (!(shl && shr)) else $error("shl and shr both high");
    end

endmodule

// File: tb/tb_sh_reg_ctrl.sv
// Self-checking bench for sh_reg_ctrl with a behavioural 8-bit shift register on
// shl/shr/d/sr_q; table-driven loads plus directed abort/reset/back-to-back sequences.
module tb_sh_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_dir, abort;
    logic [3:0] cmd_len;
    logic [7:0] cmd_data;
    logic       shl, shr, d, rsp_valid, busy;
    logic [7:0] sr_q, rsp_q;

    int checks   = 0;
    int failures = 0;
    int both_seen = 0;

    always #5 clk = ~clk;

    sh_reg_ctrl #(.WIDTH(8), .LENW(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .abort(abort),
        .shl(shl), .shr(shr), .d(d), .sr_q(sr_q),
        .rsp_valid(rsp_valid), .rsp_q(rsp_q), .busy(busy)
    );

    // Behavioural shift register, cleared by the same reset.
    always_ff @(posedge clk) begin
        if (reset)    sr_q <= 8'h00;
        else if (shl) sr_q <= {sr_q[6:0], d};
        else if (shr) sr_q <= {d, sr_q[7:1]};
    end

    always @(negedge clk) if (shl && shr) both_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       dir;
        logic [3:0] len;
        logic [7:0] data;
        int         n;
        logic [7:0] dseq;   // bit k = expected d during shift cycle k
        logic [7:0] rsp;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input string name, input logic dir, input logic [3:0] len,
                           input logic [7:0] data, input int n, input logic [7:0] dseq,
                           input logic [7:0] rsp);
        cmd_valid = 1'b1; cmd_dir = dir; cmd_len = len; cmd_data = data;
        check({name, "_ready"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_shl%0d", name, k), shl, !dir);
            check($sformatf("%s_shr%0d", name, k), shr, dir);
            check($sformatf("%s_d%0d", name, k), d, dseq[k]);
            check($sformatf("%s_busy%0d", name, k), {busy, cmd_ready}, 2'b10);
            tick();
        end
        check({name, "_cap_ctl"}, {shl, shr, d, rsp_valid}, 4'b0000);
        tick();
        check({name, "_rsp_valid"}, rsp_valid, 1);
        check({name, "_rsp_q"}, rsp_q, rsp);
        check({name, "_sr_q"}, sr_q, rsp);
        tick();
        check({name, "_rsp_pulse"}, rsp_valid, 0);
        check({name, "_rsp_hold"}, rsp_q, rsp);
    endtask

    initial begin
        int seen;
        int lat;

        vecs[0] = '{dir: 1'b0, len: 4'd8,  data: 8'hA5, n: 8, dseq: 8'hA5, rsp: 8'hA5};
        vecs[1] = '{dir: 1'b1, len: 4'd0,  data: 8'h3C, n: 8, dseq: 8'h3C, rsp: 8'h3C};
        vecs[2] = '{dir: 1'b0, len: 4'd8,  data: 8'hA5, n: 8, dseq: 8'hA5, rsp: 8'hA5};
        vecs[3] = '{dir: 1'b0, len: 4'd4,  data: 8'h0B, n: 4, dseq: 8'h0D, rsp: 8'h5B};
        vecs[4] = '{dir: 1'b1, len: 4'd4,  data: 8'h06, n: 4, dseq: 8'h06, rsp: 8'h65};
        vecs[5] = '{dir: 1'b0, len: 4'd12, data: 8'h81, n: 8, dseq: 8'h81, rsp: 8'h81};
        vecs[6] = '{dir: 1'b1, len: 4'd1,  data: 8'h01, n: 1, dseq: 8'h01, rsp: 8'hC0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = 4'd0;
        cmd_data = 8'h00; abort = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_shl", shl, 0);
        check("rst_shr", shr, 0);
        check("rst_d", d, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_q", rsp_q, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 7; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].dir, vecs[i].len, vecs[i].data,
                    vecs[i].n, vecs[i].dseq, vecs[i].rsp);

        // Abort after three shift edges of a full 0xFF load from Q=0.
        reset = 1'b1; tick(); reset = 1'b0;
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 4'd8; cmd_data = 8'hFF;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_shl", shl, 0);
        check("abort_idle", {busy, cmd_ready}, 2'b01);
        check("abort_sr_q", sr_q, 8'h07);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("abort_no_rsp", seen, 0);
        check("abort_rsp_q", rsp_q, 8'h00);
        run_cmd("post_abort", 1'b1, 4'd2, 8'h03, 2, 8'h03, 8'hC1);

        // cmd_valid together with abort in IDLE must not be accepted.
        cmd_valid = 1'b1; abort = 1'b1; cmd_dir = 1'b0; cmd_len = 4'd8; cmd_data = 8'h55;
        tick();
        cmd_valid = 1'b0; abort = 1'b0;
        check("collide_idle", {busy, cmd_ready, shl, shr}, 4'b0100);

        // Abort while in CAPTURE: no response, rsp_q untouched.
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_len = 4'd1; cmd_data = 8'h00;
        tick();
        cmd_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("capabort_rsp_valid", rsp_valid, 0);
        check("capabort_rsp_q", rsp_q, 8'hC1);
        check("capabort_idle", {busy, cmd_ready}, 2'b01);
        tick();
        check("capabort_late_rsp", rsp_valid, 0);

        // Reset in the middle of SHIFT.
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 4'd8; cmd_data = 8'hAA;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ctl", {shl, shr, d, rsp_valid}, 4'b0000);
        check("midrst_rsp_q", rsp_q, 8'h00);
        check("midrst_idle", {busy, cmd_ready}, 2'b01);

        // Back-to-back with cmd_valid held high throughout.
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 4'd3; cmd_data = 8'h05;
        tick();
        for (int i = 0; i < 3; i++) tick();
        tick();
        check("b2b_rsp1_valid", rsp_valid, 1);
        check("b2b_rsp1_q", rsp_q, 8'h05);
        check("b2b_ready_on_rsp", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("b2b_second_accept", {busy, shl, rsp_valid}, 3'b110);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        check("b2b_latency", lat, 4);
        check("b2b_rsp2_q", rsp_q, 8'h2D);

        check("never_both_shl_shr", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
